// File: rtl/ah_rr_mux_if.sv
// ah_rr_mux_if: ingress/egress valid-ready bundle for the packet-aware round-robin mux.
interface ah_rr_mux_if #(
  parameter int DATA_W  = 85,
  parameter int NUM_ING = 15,
  parameter int SEL_W   = 4
);
  logic [NUM_ING*DATA_W-1:0] ing_data;
  logic [NUM_ING-1:0]        ing_valid;
  logic [NUM_ING-1:0]        ing_last;
  logic [NUM_ING-1:0]        ing_ready;
  logic [DATA_W-1:0]         egr_data;
  logic                      egr_valid;
  logic                      egr_last;
  logic [SEL_W-1:0]          egr_src;
  logic                      egr_ready;
  modport slave (
    input  ing_data, ing_valid, ing_last, egr_ready,
    output ing_ready, egr_data, egr_valid, egr_last, egr_src
  );
  modport master (
    output ing_data, ing_valid, ing_last, egr_ready,
    input  ing_ready, egr_data, egr_valid, egr_last, egr_src
  );
endinterface

// File: rtl/ah_rr_mux.sv
// ah_rr_mux: N-to-1 packet-aware round-robin valid/ready mux with a registered egress stage.
module ah_rr_mux #(
  parameter int DATA_W  = 85,
  parameter int NUM_ING = 15,
  parameter int SEL_W   = 4
) (
  input logic         clk,
  input logic         rst_n,
  ah_rr_mux_if.slave  bus
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t           state, state_nxt;
  logic [SEL_W-1:0] rr_ptr, rr_nxt, cur, cur_nxt, grant, sel;
  logic             found, slot_free, go, accept, beat_last;
  int               idx;
  // Scan farthest-to-nearest so the port closest after rr_ptr is written last and wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = NUM_ING; k >= 1; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_ING;
      if (bus.ing_valid[idx]) begin
        grant = SEL_W'(idx);
        found = 1'b1;
      end
    end
  end
  assign slot_free     = !bus.egr_valid || bus.egr_ready;
  assign sel           = (state == LOCKED) ? cur : grant;
  assign go            = rst_n && slot_free && (state == LOCKED || found);
  assign bus.ing_ready = go ? (NUM_ING'(1) << sel) : '0;
  assign beat_last     = bus.ing_last[sel];
  assign accept        = go && bus.ing_valid[sel];
  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    cur_nxt   = cur;
    if (accept && beat_last) begin
      state_nxt = IDLE;
      rr_nxt    = sel;
    end else if (accept && state == IDLE) begin
      state_nxt = LOCKED;
      cur_nxt   = sel;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rr_ptr <= SEL_W'(NUM_ING - 1);
      cur    <= '0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_nxt;
      cur    <= cur_nxt;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.egr_valid <= 1'b0;
      bus.egr_last  <= 1'b0;
      bus.egr_data  <= '0;
      bus.egr_src   <= '0;
    end else if (accept) begin
      bus.egr_valid <= 1'b1;
      bus.egr_last  <= beat_last;
      bus.egr_data  <= bus.ing_data[sel*DATA_W +: DATA_W];
      bus.egr_src   <= sel;
    end else if (bus.egr_ready) begin
      bus.egr_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ah_rr_mux.sv
// tb_ah_rr_mux: randomized and directed checks of ah_rr_mux against a packet-level arbitration model.
module tb_ah_rr_mux;
  localparam int DW = 85;
  localparam int N  = 15;
  localparam int SW = 4;
  typedef struct packed {logic [DW-1:0] d; logic l;} beat_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  ah_rr_mux_if #(.DATA_W(DW), .NUM_ING(N), .SEL_W(SW)) bus ();
  ah_rr_mux #(.DATA_W(DW), .NUM_ING(N), .SEL_W(SW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  beat_t        q[N][$];
  logic [N-1:0] pres;
  bit           erdy, rnd_rdy;
  int           gap_pct;
  int           n_cmp, n_bad;
  bit           m_lock, m_ev, m_el;
  int           m_cur, m_ptr, m_es;
  logic [DW-1:0] m_ed;
  int           log_src[$];
  bit           log_last[$];

  task automatic drive();
    bus.ing_valid = pres;
    bus.egr_ready = erdy;
    for (int i = 0; i < N; i++) begin
      bus.ing_data[i*DW +: DW] = (q[i].size() > 0) ? q[i][0].d : '0;
      bus.ing_last[i]          = (q[i].size() > 0) ? q[i][0].l : 1'b0;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) q[i].delete();
    pres = '0; m_lock = 0; m_ptr = N - 1; m_cur = 0;
    m_ev = 0; m_el = 0; m_ed = '0; m_es = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    erdy = 1'b0;
    drive();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic add_pkt(input int p, input int len);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.d = DW'({$urandom, $urandom, $urandom});
      b.l = (k == len - 1);
      q[p].push_back(b);
    end
  endtask

  // One clock: predict ing_ready from the arbitration rules, then predict the egress register.
  task automatic cycle();
    int g;
    bit ok, acc, sf;
    logic [N-1:0] er;
    @(negedge clk);
    if (rnd_rdy) erdy = ($urandom_range(3) != 0);
    for (int i = 0; i < N; i++)
      if (!pres[i] && q[i].size() > 0 && $urandom_range(99) >= gap_pct) pres[i] = 1'b1;
    drive();
    #1;
    sf = !m_ev || erdy;
    ok = 0; g = 0;
    if (m_lock) begin ok = 1; g = m_cur; end
    else for (int k = 1; k <= N; k++) begin
      int p;
      p = (m_ptr + k) % N;
      if (!ok && pres[p]) begin ok = 1; g = p; end
    end
    er = (ok && sf) ? (N'(1) << g) : '0;
    n_cmp++;
    if (bus.ing_ready !== er) begin
      n_bad++;
      $display("FAIL ing_ready @%0t: got %h want %h", $time, bus.ing_ready, er);
    end
    acc = ok && sf && pres[g];
    @(posedge clk);
    #1;
    if (acc) begin
      m_ev = 1; m_ed = q[g][0].d; m_el = q[g][0].l; m_es = g;
      if (q[g][0].l) begin m_lock = 0; m_ptr = g; end
      else if (!m_lock) begin m_lock = 1; m_cur = g; end
      void'(q[g].pop_front());
      pres[g] = 1'b0;
    end else if (erdy) m_ev = 0;
    n_cmp++;
    if ({bus.egr_valid, bus.egr_last, bus.egr_data, bus.egr_src} !== {m_ev, m_el, m_ed, SW'(m_es)}) begin
      n_bad++;
      $display("FAIL egress @%0t: got v%b l%b s%0d d%h want v%b l%b s%0d d%h", $time,
               bus.egr_valid, bus.egr_last, bus.egr_src, bus.egr_data, m_ev, m_el, m_es, m_ed);
    end
    if (acc) begin log_src.push_back(int'(bus.egr_src)); log_last.push_back(bus.egr_last); end
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    bus.ing_valid = '1;
    bus.egr_ready = 1'b1;
    #1;
    n_cmp++;
    if (bus.ing_ready !== '0) begin n_bad++; $display("FAIL reset_ready: got %h want 0", bus.ing_ready); end
    n_cmp++;
    if ({bus.egr_valid, bus.egr_last, bus.egr_data, bus.egr_src} !== '0) begin
      n_bad++;
      $display("FAIL reset_egress: got v%b l%b s%0d d%h want all 0", bus.egr_valid, bus.egr_last, bus.egr_src, bus.egr_data);
    end
    do_reset();
  endtask

  task automatic test_single_port();
    int exp_l[] = '{0, 0, 0, 1};
    erdy = 1; log_src.delete(); log_last.delete();
    add_pkt(3, 4);
    repeat (5) cycle();
    n_cmp++;
    if (log_src.size() != 4) begin n_bad++; $display("FAIL single_count: got %0d want 4", log_src.size()); end
    for (int i = 0; i < 4 && i < log_src.size(); i++) begin
      n_cmp++;
      if (log_src[i] != 3 || log_last[i] != exp_l[i]) begin
        n_bad++;
        $display("FAIL single_beat%0d: got src %0d last %b want src 3 last %0d", i, log_src[i], log_last[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_rr_order();
    int exp_s[] = '{0, 5, 14, 0, 5, 14};
    do_reset();
    erdy = 1; log_src.delete(); log_last.delete();
    for (int r = 0; r < 2; r++) begin add_pkt(0, 1); add_pkt(5, 1); add_pkt(14, 1); end
    repeat (6) cycle();
    n_cmp++;
    if (log_src.size() != 6) begin n_bad++; $display("FAIL rr_count: got %0d want 6", log_src.size()); end
    for (int i = 0; i < 6 && i < log_src.size(); i++) begin
      n_cmp++;
      if (log_src[i] != exp_s[i]) begin n_bad++; $display("FAIL rr_order%0d: got %0d want %0d", i, log_src[i], exp_s[i]); end
    end
  endtask

  task automatic test_lock();
    int exp_s[] = '{2, 2, 2, 1};
    erdy = 1; log_src.delete(); log_last.delete();
    add_pkt(2, 3);
    cycle();
    add_pkt(1, 1);
    repeat (3) cycle();
    n_cmp++;
    if (log_src.size() != 4) begin n_bad++; $display("FAIL lock_count: got %0d want 4", log_src.size()); end
    for (int i = 0; i < 4 && i < log_src.size(); i++) begin
      n_cmp++;
      if (log_src[i] != exp_s[i]) begin n_bad++; $display("FAIL lock_order%0d: got %0d want %0d", i, log_src[i], exp_s[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] held;
    erdy = 1; log_src.delete(); log_last.delete();
    add_pkt(4, 2);
    cycle();
    held = q[4].size() == 1 ? m_ed : '0;
    erdy = 0;
    repeat (3) begin
      cycle();
      n_cmp++;
      if (bus.egr_data !== held || bus.egr_src !== SW'(4) || bus.egr_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL bp_hold: got v%b s%0d d%h want v1 s4 d%h", bus.egr_valid, bus.egr_src, bus.egr_data, held);
      end
    end
    erdy = 1;
    cycle();
    n_cmp++;
    if (log_src.size() != 2) begin n_bad++; $display("FAIL bp_resume: got %0d beats want 2", log_src.size()); end
    cycle();
  endtask

  task automatic test_wrap();
    int exp_s[] = '{14, 0};
    do_reset();
    erdy = 1;
    add_pkt(13, 1);
    cycle();
    log_src.delete(); log_last.delete();
    add_pkt(14, 1); add_pkt(0, 1);
    repeat (3) cycle();
    n_cmp++;
    if (log_src.size() != 2) begin n_bad++; $display("FAIL wrap_count: got %0d want 2", log_src.size()); end
    for (int i = 0; i < 2 && i < log_src.size(); i++) begin
      n_cmp++;
      if (log_src[i] != exp_s[i]) begin n_bad++; $display("FAIL wrap_order%0d: got %0d want %0d", i, log_src[i], exp_s[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int exp_s[] = '{0, 6};
    erdy = 1;
    add_pkt(6, 4);
    repeat (2) cycle();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.egr_valid !== 1'b0 || bus.ing_ready !== '0) begin
      n_bad++;
      $display("FAIL async_reset: got v%b ready %h want v0 ready 0", bus.egr_valid, bus.ing_ready);
    end
    do_reset();
    erdy = 1; log_src.delete(); log_last.delete();
    add_pkt(6, 1); add_pkt(0, 1);
    repeat (3) cycle();
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (log_src.size() <= i || log_src[i] != exp_s[i]) begin
        n_bad++;
        $display("FAIL post_reset_order%0d: got %0d want %0d", i, log_src.size() > i ? log_src[i] : -1, exp_s[i]);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    gap_pct = 30; rnd_rdy = 1;
    for (int c = 0; c < 1500; c++) begin
      int p;
      p = $urandom_range(N - 1);
      if (q[p].size() < 6 && $urandom_range(3) == 0) add_pkt(p, $urandom_range(1, 4));
      cycle();
    end
    rnd_rdy = 0; erdy = 1; gap_pct = 0;
    repeat (200) cycle();
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (q[i].size() != 0) begin n_bad++; $display("FAIL drain_port%0d: %0d beats left want 0", i, q[i].size()); end
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; gap_pct = 0; rnd_rdy = 0; erdy = 0;
    model_reset();
    drive();
    test_reset();
    test_single_port();
    test_rr_order();
    test_lock();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ah_rr_mux.md
Name: ah_rr_mux

Overview:
- N-to-1 packet-aware valid/ready multiplexer; the merge-side counterpart of the AH demux family.
- Collects streams from NUM_ING ingress ports onto one egress stream using round-robin arbitration.
- Holds the grant for a whole packet, from the first beat through the beat with last=1.
- Registered egress stage gives full throughput and one cycle of latency; sits in front of shared downstream consumers.

Parameters:
- DATA_W, 85, width of each data beat.
- NUM_ING, 15, number of ingress ports (legal range 2..16).
- SEL_W, 4, width of the source index; must satisfy 2^SEL_W >= NUM_ING.

Ports:
- clk  input  1  single clock; all flops rise-edge.
- rst_n  input  1  asynchronous active-low reset.
- ing_data  input  NUM_ING*DATA_W  flattened ingress data; port i occupies bits [i*DATA_W +: DATA_W].
- ing_valid  input  NUM_ING  per-port valid.
- ing_last  input  NUM_ING  per-port end-of-packet flag, qualified by valid.
- ing_ready  output  NUM_ING  per-port ready.
- egr_data  output  DATA_W  egress data (registered).
- egr_valid  output  1  egress valid (registered).
- egr_last  output  1  egress end-of-packet (registered).
- egr_src  output  SEL_W  index of the ingress port that sourced the current egress beat (registered).
- egr_ready  input  1  downstream ready.

Behaviour:
- Handshake rules:
  - A transfer occurs on a port when valid && ready are both high at a clk edge.
  - Sources hold data, last and valid stable until accepted.
  - The block holds egr_* stable while egr_valid && !egr_ready.
- Reset (rst_n=0, asynchronous):
  - egr_valid=0, egr_last=0, egr_data=0, egr_src=0.
  - state=IDLE; rr_ptr=NUM_ING-1, so port 0 has first priority.
  - All ing_ready bits read 0 while in reset.
- slot_free = !egr_valid || egr_ready.
- State IDLE:
  - grant = first i with ing_valid[i]=1, searching (rr_ptr+1), (rr_ptr+2), ... modulo NUM_ING.
  - ing_ready[grant] = slot_free; all other ing_ready bits are 0.
  - With no valid port, all ing_ready bits are 0 and the state holds.
  - Accepted beat with last=0: go to LOCKED, cur=grant.
  - Accepted beat with last=1 (single-beat packet): stay in IDLE, rr_ptr=grant.
- State LOCKED:
  - Only ing_ready[cur] may be high, and equals slot_free.
  - ing_valid on other ports is ignored.
  - An idle gap on cur (valid=0) keeps the lock; the state holds.
  - Accepted beat with last=1: go to IDLE, rr_ptr=cur.
- Egress register:
  - On an accepted ingress beat: load egr_data, egr_last and egr_src, and set egr_valid=1.
  - Else, if egr_ready=1: egr_valid=0.
  - Otherwise hold.
- Latency: exactly 1 cycle from ingress acceptance to egr_valid.
- Throughput: 1 beat/cycle when egr_ready is held high. Back-to-back packets from different ports have no idle cycle between them.
- Wrap-around: the search index wraps from NUM_ING-1 to 0.
- Combinational paths:
  - ing_ready depends on ing_valid in IDLE only.
  - No combinational path from ing_* to egr_*.
  - egr_ready reaches ing_ready combinationally through slot_free.
- Reset mid-packet: immediately returns to IDLE with the reset values; the partial packet downstream is not terminated. Recovery is the upstream's responsibility.
- egr_src only changes on a loaded beat.

Test Plan:
- Only port 3 sends 4 beats (last on beat 4), egr_ready=1 -> egr_valid from cycle+1 for 4 cycles, egr_src=3 on all beats, egr_last on beat 4 only, ing_ready[3]=1 throughout.
- After reset, ports 0, 5 and 14 each present a 1-beat packet simultaneously and continuously -> grant order 0, 5, 14, 0, 5, ...; egr_src shows this sequence with no gaps.
- Port 2 starts a 3-beat packet and port 1 asserts valid during beat 2 -> port 1 stays unready until port 2's last beat is accepted; port 1's beat follows on the next cycle.
- egr_ready=0 for 3 cycles with egr_valid=1 -> egr_data, egr_last and egr_src held; all ing_ready=0; first ingress beat accepted in the cycle egr_ready returns to 1.
- rr_ptr=13, ports 14 and 0 valid -> port 14 granted first, then port 0 (wrap).
- rst_n pulsed low mid-packet on port 6 -> egr_valid=0 asynchronously; after release, port 0 has priority over a pending port 6.
